// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD datapath/controller pair: default width, controller state
// encoding (so benches can decode the controller's state) and the result type.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 8;

  // Controller state encoding; owned by the controller, published here for observers.
  localparam int unsigned GCD_STATE_W = 3;
  localparam logic [GCD_STATE_W-1:0] start_check = 3'd0;
  localparam logic [GCD_STATE_W-1:0] check_eq    = 3'd1;
  localparam logic [GCD_STATE_W-1:0] check_gt    = 3'd2;
  localparam logic [GCD_STATE_W-1:0] sub_a       = 3'd3;
  localparam logic [GCD_STATE_W-1:0] sub_b       = 3'd4;
  localparam logic [GCD_STATE_W-1:0] assign_res  = 3'd5;

  typedef logic [GCD_WIDTH-1:0] gcd_result_t;

  function automatic bit gcd_is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/gcd_datapath_if.sv
// Issuer/controller <-> datapath signal bundle: operand load, sel/wr strobes, status flags and
// the result FIFO valid/ready handshake.
interface gcd_datapath_if #(
  parameter int unsigned WIDTH = gcd_pkg::GCD_WIDTH
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sel_A;
  logic             sel_B;
  logic             wr_A;
  logic             wr_B;
  logic             wr_res;
  logic             a_eq_b;
  logic             a_gt_b;
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             res_full;
  logic             ovf_clr;
  logic             res_ovf;

  modport master (
    output a_in, b_in, sel_A, sel_B, wr_A, wr_B, wr_res, res_ready, ovf_clr,
    input  a_eq_b, a_gt_b, res_data, res_valid, res_full, res_ovf
  );

  modport slave (
    input  a_in, b_in, sel_A, sel_B, wr_A, wr_B, wr_res, res_ready, ovf_clr,
    output a_eq_b, a_gt_b, res_data, res_valid, res_full, res_ovf
  );

endinterface

// File: rtl/gcd_result_fifo.sv
// Small result FIFO with valid/ready pop side, drop-on-full push and a sticky overflow flag.
module gcd_result_fifo
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH     = GCD_WIDTH,
  parameter int unsigned RES_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  output logic             res_full,
  output logic             res_ovf
);

  localparam int unsigned PtrW = $clog2(RES_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [RES_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             ovf_q;

  logic empty, full, pop, push_ok, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(RES_DEPTH));
  assign pop   = pop_req && !empty;
  // A pop in the same cycle frees the slot the push lands in (wr_ptr == rd_ptr when full).
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RES_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign res_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign res_valid = !empty;
  assign res_full  = full;
  assign res_ovf   = ovf_q;

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: operand registers A/B with subtract-and-replace, comparators and result FIFO.
// Optional macro GCD_ZERO_GUARD_EN terminates the controller loop for zero operands.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH     = GCD_WIDTH,
  parameter int unsigned RES_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  gcd_datapath_if.slave   dp
);

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] diff_ab, diff_ba;
  logic [WIDTH-1:0] push_data;
  logic             raw_eq, raw_gt;

  // Modulo 2^WIDTH; a wrap means the controller subtracted the wrong way round.
  assign diff_ab = a_q - b_q;
  assign diff_ba = b_q - a_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (dp.wr_A) begin
        a_q <= dp.sel_A ? diff_ab : dp.a_in;
      end
      if (dp.wr_B) begin
        b_q <= dp.sel_B ? diff_ba : dp.b_in;
      end
    end
  end

  assign raw_eq = (a_q == b_q);
  assign raw_gt = (a_q > b_q);

`ifdef GCD_ZERO_GUARD_EN
  logic any_zero;
  assign any_zero  = (a_q == '0) || (b_q == '0);
  assign dp.a_eq_b = any_zero || raw_eq;
  assign dp.a_gt_b = !any_zero && raw_gt;
  // With one operand zero the other is the answer; both zero yields zero.
  assign push_data = a_q | b_q;
`else
  assign dp.a_eq_b = raw_eq;
  assign dp.a_gt_b = raw_gt;
  assign push_data = a_q;
`endif

  gcd_result_fifo #(
    .WIDTH     (WIDTH),
    .RES_DEPTH (RES_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dp.wr_res),
    .push_data (push_data),
    .pop_req   (dp.res_ready),
    .ovf_clr   (dp.ovf_clr),
    .res_data  (dp.res_data),
    .res_valid (dp.res_valid),
    .res_full  (dp.res_full),
    .res_ovf   (dp.res_ovf)
  );

endmodule

// File: doc/gcd_datapath.md
Name: gcd_datapath

Overview:
Datapath partner of the GCD controller FSM. It holds operand registers A and B and performs subtract-and-replace under the controller's sel/wr strobes. It returns the a_eq_b/a_gt_b status flags to the controller. Finished results are buffered in a small result FIFO with a valid/ready output handshake, so the consumer can stall without losing results.

Parameters:
WIDTH, 8, operand/result bit width (unsigned)
RES_DEPTH, 2, result FIFO depth; power of 2, >= 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
a_in  input  WIDTH  operand A from issuer
b_in  input  WIDTH  operand B from issuer
sel_A  input  1  0: A loads a_in; 1: A loads A-B
sel_B  input  1  0: B loads b_in; 1: B loads B-A
wr_A  input  1  A register write enable
wr_B  input  1  B register write enable
wr_res  input  1  push current A into result FIFO
a_eq_b  output  1  combinational, A == B
a_gt_b  output  1  combinational, A > B (unsigned)
res_data  output  WIDTH  FIFO head
res_valid  output  1  FIFO not empty
res_ready  input  1  consumer accepts head
res_full  output  1  FIFO holds RES_DEPTH entries; issuer must not assert start
ovf_clr  input  1  synchronous clear of res_ovf
res_ovf  output  1  sticky: a result was dropped

Behaviour:
- Interface decided: one clock clk; reset rst is asynchronous and active-high.
- Reset (async, immediate):
  - A = B = 0
  - FIFO empty: res_valid=0, res_full=0
  - res_data = 0
  - res_ovf = 0
  - Consequently a_eq_b=1 and a_gt_b=0 while in reset.
- Operand registers, per posedge:
  - wr_A: A <= sel_A ? (A-B) : a_in
  - wr_B: B <= sel_B ? (B-A) : b_in
  - Both writes in the same cycle use pre-edge values of A and B.
- Arithmetic is modulo 2^WIDTH; no underflow detection. The controller only subtracts smaller from larger, so a wrap indicates a controller bug and is not flagged.
- Flags are purely combinational from the registered A and B; there is no extra latency.
- Result push: wr_res at edge N writes the pre-edge A. res_valid is high after edge N; push-to-valid latency is 1 cycle.
- Pop: res_valid && res_ready at an edge advances the head. res_data is the head entry; it is 0 when empty and the consumer must ignore it.
- Full:
  - A push while full with no pop is dropped; FIFO contents are unchanged and res_ovf is set.
  - A push while full with a simultaneous pop is accepted; count stays RES_DEPTH.
- Empty: a pop when empty is ignored (res_valid=0 qualifies it).
- Same-cycle set and ovf_clr: set wins.
- Read/write pointers are log2(RES_DEPTH) bits wide, wrap naturally, plus a count register.
- No FSM inside this block; sequencing is owned by the controller.

Optional Feature:
GCD_ZERO_GUARD_EN
- Defined:
  - If A==0 or B==0, a_eq_b is forced to 1 and a_gt_b to 0.
  - wr_res pushes A|B, i.e. the nonzero operand, or 0 if both are zero.
  - This terminates the controller loop for zero operands.
- Undefined:
  - Flags are raw comparisons and wr_res pushes A.
  - A zero operand with a nonzero partner hangs the controller; this is documented as illegal input.

Decomposition:
- Shared package gcd_pkg holds:
  - GCD_WIDTH default
  - the controller state localparams (start_check … assign_res), so benches can decode the controller's state
  - a gcd_result_t typedef of width WIDTH
- One sub-module, gcd_result_fifo (parameters WIDTH, RES_DEPTH):
  - handles push, pop, full, overflow and ovf_clr
  - the top level keeps the operand registers and the comparators.

Test Plan:
- Load: a_in=48, b_in=18, wr_A=wr_B=1, sel=0 -> next cycle A=48, B=18, a_gt_b=1, a_eq_b=0.
- Full GCD sequence driven by the controller with inputs 48/18 -> after the wr_res edge, res_valid=1, res_data=6; one pop with res_ready=1 -> res_valid=0.
- Overflow, res_ready=0: push 6, push 5 -> res_full=1; push 7 -> dropped, res_ovf=1; then pop twice -> 6 then 5; ovf_clr -> res_ovf=0.
- Full with simultaneous push 9 and pop -> count stays 2; pop order 5, 9 (starting from 6, 5).
- Reset mid-operation: assert rst during a subtract loop with A=30, B=12 -> A=B=0, res_valid=0, res_ovf=0 immediately, with no clock edge needed.
- Zero operand, a=0, b=9:
  - with GCD_ZERO_GUARD_EN: a_eq_b=1, result 9
  - without: a_eq_b=0, a_gt_b=0
